// File: rtl/pcie_rq_tlp_gen.sv
// Requester TLP builder: turns MRd/MWr commands plus a packed payload stream
// into DW-aligned RQ beats (4 DW descriptor followed by payload) with sideband.
module pcie_rq_tlp_gen #(
   parameter int          DWIDTH     = 256,
   parameter int          MAX_LEN_DW = 256,
   parameter logic [15:0] REQ_ID     = 16'h0
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_type,
   input  logic [63:0]       cmd_addr,
   input  logic [10:0]       cmd_len,
   input  logic [7:0]        cmd_tag,
   input  logic [3:0]        cmd_fbe,
   input  logic [3:0]        cmd_lbe,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              wr_valid,
   input  logic              wr_err,
   output logic              wr_ready,
   output logic [DWIDTH-1:0] rq_oper_data,
   output logic [15:0]       rq_oper_data_ex,
   output logic              rq_oper_wen,
   input  logic              rq_oper_ready,
   output logic              busy
);
   localparam int N    = DWIDTH / 32;
   localparam int LOGN = $clog2(N);
   localparam bit W256 = (DWIDTH == 256);

   typedef enum logic [1:0] {IDLE, HDR, DATA, TAIL} state_t;
   state_t state, state_nxt;

   logic             c_wr;
   logic [63:2]      c_addr;
   logic [10:0]      c_len;
   logic [7:0]       c_tag;
   logic [3:0]       c_fbe, c_lbe;
   logic [11:0]      wcnt;        // index of the next payload word to take
   logic [3:0][31:0] held;        // upper half of the previous 256-bit word
   logic             held_err;

   logic [11:0]      len_w, base, last_word, lm;
   logic [3:0][31:0] desc, lo_dw, hi_dw;
   logic [N-1:0][31:0] beat;
   logic             fire, take, store, sop, eop, err, last, tail;
   logic [3:0]       keep;
   logic [15:0]      ex_nxt;
   logic             unused;

   // byte offset bits of the address carry no meaning for DW-aligned TLPs
   assign unused = ^cmd_addr[1:0];

   assign len_w     = {1'b0, c_len};
   assign base      = wcnt << LOGN;
   assign last_word = ((len_w + 12'(N - 1)) >> LOGN) - 12'd1;
   assign lm        = W256 ? (len_w + 12'd3) : (len_w - 12'd1);

   assign desc[0] = {c_addr[31:2], 2'b00};
   assign desc[1] = c_addr[63:32];
   assign desc[2] = {REQ_ID, 1'b0, 3'b000, c_wr, c_len};
   assign desc[3] = {8'h0, 16'h0, c_tag};

   assign wr_ready = rq_oper_ready && ((state == HDR && c_wr && W256) || state == DATA);

   // current payload word split into lower/upper 4 DW, DWs beyond len zeroed
   always_comb begin
      lo_dw = '0;
      hi_dw = '0;
      for (int i = 0; i < 4; i++)
         if (base + 12'(i) < len_w) lo_dw[i] = wr_data[32*i +: 32];
      for (int i = 4; i < N; i++)
         if (base + 12'(i) < len_w) hi_dw[i-4] = wr_data[32*i +: 32];
   end

   // next-state, beat assembly and handshake decisions
   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      take      = 1'b0;
      store     = 1'b0;
      beat      = '0;
      sop       = 1'b0;
      eop       = 1'b0;
      err       = 1'b0;
      last      = (wcnt == last_word);
      tail      = 1'b0;
      case (state)
         IDLE: if (cmd_valid && cmd_ready) state_nxt = HDR;
         HDR: begin
            for (int i = 0; i < 4; i++) beat[i] = desc[i];
            sop = 1'b1;
            if (!c_wr) begin
               fire = rq_oper_ready;
               eop  = 1'b1;
               if (fire) state_nxt = IDLE;
            end else if (W256) begin
               // payload word 0 rides in the upper half of the descriptor beat
               fire  = rq_oper_ready && wr_valid;
               take  = fire;
               store = fire;
               for (int i = 4; i < N; i++) beat[i] = lo_dw[i-4];
               eop = (len_w <= 12'd4);
               err = wr_err;
               if (fire) state_nxt = eop ? IDLE : (last_word != 12'd0 ? DATA : TAIL);
            end else begin
               fire = rq_oper_ready;
               if (fire) state_nxt = DATA;
            end
         end
         DATA: begin
            fire = rq_oper_ready && wr_valid;
            take = fire;
            if (W256) begin
               store = fire;
               for (int i = 0; i < 4; i++) beat[i] = held[i];
               for (int i = 4; i < N; i++) beat[i] = lo_dw[i-4];
               // upper half of the last word still has valid DW -> one more beat
               tail = last && (len_w > base + 12'd4);
               eop  = last && !tail;
               err  = held_err || wr_err;
               if (fire && last) state_nxt = tail ? TAIL : IDLE;
            end else begin
               for (int i = 0; i < 4; i++) beat[i] = lo_dw[i];
               eop = last;
               err = wr_err;
               if (fire && last) state_nxt = IDLE;
            end
         end
         TAIL: begin
            for (int i = 0; i < 4; i++) beat[i] = held[i];
            fire = rq_oper_ready;
            eop  = 1'b1;
            err  = held_err;
            if (fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      keep = 4'h0;
      if (eop) keep = !c_wr ? 4'd3 : (W256 ? {1'b0, lm[2:0]} : {2'b00, lm[1:0]});
      ex_nxt = {sop, eop, err, 1'b0, keep,
                sop ? c_fbe : 4'h0,
                (sop && c_len != 11'd1) ? c_lbe : 4'h0};
   end

   // state register
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) state <= IDLE;
      else             state <= state_nxt;
   end

   // command capture, payload bookkeeping and registered beat outputs
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         c_wr            <= 1'b0;
         c_addr          <= '0;
         c_len           <= '0;
         c_tag           <= '0;
         c_fbe           <= '0;
         c_lbe           <= '0;
         wcnt            <= '0;
         held            <= '0;
         held_err        <= 1'b0;
         busy            <= 1'b0;
         cmd_ready       <= 1'b0;
         rq_oper_wen     <= 1'b0;
         rq_oper_data    <= '0;
         rq_oper_data_ex <= '0;
      end else begin
         cmd_ready   <= (state_nxt == IDLE);
         rq_oper_wen <= fire;
         if (state == IDLE && cmd_valid && cmd_ready) begin
            c_wr   <= cmd_type;
            c_addr <= cmd_addr[63:2];
            c_len  <= cmd_len;
            c_tag  <= cmd_tag;
            c_fbe  <= cmd_fbe;
            c_lbe  <= cmd_lbe;
            wcnt   <= '0;
            busy   <= 1'b1;
         end
         if (take) wcnt <= wcnt + 12'd1;
         if (store) begin
            held     <= hi_dw;
            held_err <= wr_err;
         end
         if (fire) begin
            rq_oper_data    <= beat;
            rq_oper_data_ex <= ex_nxt;
            if (eop) busy <= 1'b0;
         end
      end
   end

   // illegal lengths have no defined behaviour; flag them in simulation
   always_ff @(posedge user_clk) begin
      if (user_rst_n && cmd_valid && cmd_ready)
         assert (cmd_len != 11'd0 && 32'(cmd_len) <= MAX_LEN_DW);
   end
endmodule

// File: tb/tb_pcie_rq_tlp_gen.sv
// Bench for pcie_rq_tlp_gen (256-bit): directed spec cases plus random packets
// checked against a DW-stream reference model.
module tb_pcie_rq_tlp_gen;
   localparam int N = 8;

   logic         user_clk, user_rst_n;
   logic         cmd_valid, cmd_ready, cmd_type;
   logic [63:0]  cmd_addr;
   logic [10:0]  cmd_len;
   logic [7:0]   cmd_tag;
   logic [3:0]   cmd_fbe, cmd_lbe;
   logic [255:0] wr_data;
   logic         wr_valid, wr_err, wr_ready;
   logic [255:0] rq_oper_data;
   logic [15:0]  rq_oper_data_ex;
   logic         rq_oper_wen, rq_oper_ready, busy;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   logic [255:0] got_data[$];
   logic [15:0]  got_ex[$];

   pcie_rq_tlp_gen #(.DWIDTH(256), .MAX_LEN_DW(256), .REQ_ID(16'h0)) dut (
      .user_clk(user_clk), .user_rst_n(user_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
      .cmd_fbe(cmd_fbe), .cmd_lbe(cmd_lbe),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_err(wr_err), .wr_ready(wr_ready),
      .rq_oper_data(rq_oper_data), .rq_oper_data_ex(rq_oper_data_ex),
      .rq_oper_wen(rq_oper_wen), .rq_oper_ready(rq_oper_ready), .busy(busy)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
      checks++;
      assert (obs === want) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   // Drives one command and its payload; the expected beats come from laying
   // descriptor + payload out as one DW stream and cutting it into 8-DW beats.
   task automatic run_pkt(input bit wr, input logic [63:0] addr, input int len,
                          input logic [7:0] tag, input logic [3:0] fbe, input logic [3:0] lbe,
                          input int stall_pct, input int gap_pct, input int err_pct,
                          input int abort_after);
      logic [255:0] words[$];
      bit           werr[$];
      logic [31:0]  s[$];
      logic [255:0] exp_d[$];
      logic [15:0]  exp_x[$];
      logic [255:0] w, bd;
      bit           e, acc, took_c, took_w, rdy;
      int           nw, nb, wi, bi, cyc, idx;
      nw = wr ? (len + N - 1) / N : 0;
      for (int k = 0; k < nw; k++) begin
         for (int d = 0; d < N; d++) w[32*d +: 32] = $urandom;
         words.push_back(w);
         werr.push_back($urandom_range(99) < err_pct);
      end
      s.push_back({addr[31:2], 2'b00});
      s.push_back(addr[63:32]);
      s.push_back((32'(wr) << 11) | 32'(len));
      s.push_back(32'(tag));
      if (wr)
         for (int p = 0; p < len; p++) begin
            w = words[p / N];
            s.push_back(w[32*(p % N) +: 32]);
         end
      nb = (s.size() + N - 1) / N;
      for (int b = 0; b < nb; b++) begin
         bd = '0;
         e  = 1'b0;
         for (int d = 0; d < N; d++) begin
            idx = b * N + d;
            if (idx < s.size()) begin
               bd[32*d +: 32] = s[idx];
               if (idx >= 4 && werr[(idx - 4) / N]) e = 1'b1;
            end
         end
         exp_d.push_back(bd);
         exp_x.push_back({b == 0, b == nb - 1, e, 1'b0,
                          (b == nb - 1) ? 4'((s.size() - 1) % N) : 4'h0,
                          (b == 0) ? fbe : 4'h0,
                          (b == 0 && len != 1) ? lbe : 4'h0});
      end
      got_data.delete();
      got_ex.delete();
      acc = 0; wi = 0; bi = 0; cyc = 0;
      while (bi < nb && cyc < 3000) begin
         @(negedge user_clk);
         cmd_valid     = !acc;
         cmd_type      = wr;
         cmd_addr      = addr;
         cmd_len       = 11'(len);
         cmd_tag       = tag;
         cmd_fbe       = fbe;
         cmd_lbe       = lbe;
         rq_oper_ready = ($urandom_range(99) >= stall_pct);
         if (wi < nw) begin
            wr_valid = ($urandom_range(99) >= gap_pct);
            wr_data  = words[wi];
            wr_err   = werr[wi];
         end else begin
            wr_valid = 1'b0;
            wr_data  = '0;
            wr_err   = 1'b0;
         end
         #1;
         took_c = cmd_valid && cmd_ready;
         took_w = wr_valid && wr_ready;
         rdy    = rq_oper_ready;
         @(posedge user_clk);
         #1;
         if (took_c) begin
            acc = 1;
            chk("busy_after_accept", 256'(busy), 256'(1));
         end
         if (took_w) wi++;
         if (rq_oper_wen) begin
            chk("wen_needs_ready", 256'(rdy), 256'(1));
            if (bi < nb) begin
               chk($sformatf("beat%0d_data", bi), rq_oper_data, exp_d[bi]);
               chk($sformatf("beat%0d_ex", bi), 256'(rq_oper_data_ex), 256'(exp_x[bi]));
            end
            got_data.push_back(rq_oper_data);
            got_ex.push_back(rq_oper_data_ex);
            bi++;
            if (bi == nb) chk("busy_clear_at_eop", 256'(busy), 256'(0));
            if (abort_after > 0 && bi == abort_after) return;
         end
         cyc++;
      end
      chk("beats_written", 256'(bi), 256'(nb));
      chk("words_taken", 256'(wi), 256'(nw));
      @(negedge user_clk);
      cmd_valid     = 1'b0;
      wr_valid      = 1'b0;
      rq_oper_ready = 1'b1;
      #1;
      chk("idle_cmd_ready", 256'(cmd_ready), 256'(1));
      @(posedge user_clk);
      #1;
      chk("no_extra_wen", 256'(rq_oper_wen), 256'(0));
   endtask

   initial begin
      user_rst_n    = 1'b0;
      cmd_valid     = 1'b0;
      cmd_type      = 1'b0;
      cmd_addr      = '0;
      cmd_len       = '0;
      cmd_tag       = '0;
      cmd_fbe       = '0;
      cmd_lbe       = '0;
      wr_data       = '0;
      wr_valid      = 1'b0;
      wr_err        = 1'b0;
      rq_oper_ready = 1'b1;
      #12;
      chk("rst_wen", 256'(rq_oper_wen), 256'(0));
      chk("rst_data", rq_oper_data, 256'(0));
      chk("rst_ex", 256'(rq_oper_data_ex), 256'(0));
      chk("rst_cmd_ready", 256'(cmd_ready), 256'(0));
      chk("rst_wr_ready", 256'(wr_ready), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      @(negedge user_clk);
      user_rst_n = 1'b1;

      // MRd single beat
      run_pkt(1'b0, 64'h1000_0040, 16, 8'd5, 4'hF, 4'hF, 0, 0, 0, 0);
      chk("mrd_beats", 256'(got_ex.size()), 256'(1));
      chk("mrd_ex", 256'(got_ex[0]), 256'(16'hC3FF));
      chk("mrd_desc", got_data[0], {128'h0, 128'h00000005_00000010_00000000_10000040});

      // MWr len 1: LBE forced to 0
      run_pkt(1'b1, 64'h2000, 1, 8'd1, 4'h3, 4'hF, 0, 0, 0, 0);
      chk("mwr1_ex", 256'(got_ex[0]), 256'(16'hC430));
      chk("mwr1_upper_zero", 256'(got_data[0][255:160]), 256'(0));

      // MWr len 12: two beats
      run_pkt(1'b1, 64'h3000, 12, 8'd2, 4'hF, 4'hF, 0, 0, 0, 0);
      chk("mwr12_beats", 256'(got_ex.size()), 256'(2));
      chk("mwr12_ex0", 256'(got_ex[0]), 256'(16'h80FF));
      chk("mwr12_ex1", 256'(got_ex[1]), 256'(16'h4700));
      chk("mwr12_dw2", 256'(got_data[0][95:64]), 256'(32'h0000080C));

      // MWr len 13: tail beat with a single DW
      run_pkt(1'b1, 64'h4000, 13, 8'd3, 4'hF, 4'hF, 0, 0, 0, 0);
      chk("mwr13_beats", 256'(got_ex.size()), 256'(3));
      chk("mwr13_ex2", 256'(got_ex[2]), 256'(16'h4000));
      chk("mwr13_tail_upper", 256'(got_data[2][255:32]), 256'(0));

      // back-pressure and payload gaps
      run_pkt(1'b1, 64'h5000, 32, 8'd4, 4'hF, 4'hF, 40, 30, 0, 0);
      // poisoned payload on every word
      run_pkt(1'b1, 64'h6000, 20, 8'd6, 4'hF, 4'h7, 10, 10, 100, 0);

      // reset in the middle of a packet
      run_pkt(1'b1, 64'h7000, 32, 8'd7, 4'hF, 4'hF, 0, 0, 0, 2);
      #2;
      user_rst_n = 1'b0;
      #1;
      chk("midrst_wen", 256'(rq_oper_wen), 256'(0));
      chk("midrst_cmd_ready", 256'(cmd_ready), 256'(0));
      chk("midrst_wr_ready", 256'(wr_ready), 256'(0));
      chk("midrst_busy", 256'(busy), 256'(0));
      @(negedge user_clk);
      cmd_valid = 1'b0;
      wr_valid  = 1'b0;
      @(negedge user_clk);
      user_rst_n = 1'b1;
      run_pkt(1'b1, 64'h8000_0000_0000_8000, 20, 8'd8, 4'hC, 4'h3, 0, 0, 0, 0);

      // random mix
      for (int r = 0; r < 25; r++)
         run_pkt($urandom_range(1), {$urandom, $urandom}, ($urandom_range(3) == 0) ?
                 $urandom_range(256, 1) : $urandom_range(40, 1),
                 8'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(50), $urandom_range(50), 20, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
